// File: rtl/lab_arb_pkg.sv
// Shared types and helpers for the lab_encoder_arbiter slice.
// Optional feature macro: LAB_ARB_ROUND_ROBIN_EN (round-robin priority).
package lab_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    localparam int LAB_ARB_CNT_W = 8;

    // One-hot image of idx; indices outside 0..n-1 give an all-zero vector.
    function automatic logic [31:0] onehot(input logic [4:0] idx, input int n);
        logic [31:0] result;
        result = (int'(idx) < n) ? (32'd1 << idx) : 32'd0;
        return result;
    endfunction

endpackage

// File: rtl/lab_prio_pick.sv
// Combinational downward priority search with wrap-around.
// Starting at index 'start', scans start, start-1, ..., 0, N-1, ... and
// reports the first set request line as the winner.
module lab_prio_pick #(
    parameter int N = 5,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [W-1:0] win,
    output logic         found
);

    int           idx_s;
    logic [W-1:0] pos_s;
    logic         hit_s;

    // Walk all N positions from the start index downward, keeping the first hit.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx_s = 0;
        pos_s = '0;
        hit_s = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx_s = int'(start) - k;
            idx_s = (idx_s < 0) ? (idx_s + N) : idx_s;
            pos_s = W'(idx_s);
            hit_s = req[pos_s] & ~found;
            win   = hit_s ? pos_s : win;
            found = found | hit_s;
        end
    end

endmodule

// File: rtl/lab_encoder_arbiter.sv
// Registered N-input priority encoder with grant hold and acknowledge.
// A winner is latched in IDLE and held until the consumer acknowledges it.
// Optional feature macro: LAB_ARB_ROUND_ROBIN_EN selects round-robin
// priority (ptr register present); undefined gives fixed highest-index
// priority. The port list is identical in both builds.
module lab_encoder_arbiter
    import lab_arb_pkg::*;
#(
    parameter  int N = 5,
    localparam int W = $clog2(N)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N-1:0]             req,
    input  logic                     ack,
    output logic [W-1:0]             code,
    output logic [N-1:0]             grant,
    output logic                     valid,
    output logic [LAB_ARB_CNT_W-1:0] count
);

    arb_state_t               state_r, state_nxt;
    logic [W-1:0]             code_r, code_nxt;
    logic [N-1:0]             grant_r, grant_nxt;
    logic                     valid_r, valid_nxt;
    logic [LAB_ARB_CNT_W-1:0] count_r, count_nxt;
    logic [W-1:0]             start_s;
    logic [W-1:0]             win_s;
    logic                     found_s;

`ifdef LAB_ARB_ROUND_ROBIN_EN
    logic [W-1:0]             ptr_r, ptr_nxt;
    assign start_s = ptr_r;
`else
    assign start_s = W'(N - 1);
`endif

    lab_prio_pick #(
        .N (N),
        .W (W)
    ) u_pick (
        .req   (req),
        .start (start_s),
        .win   (win_s),
        .found (found_s)
    );

    // Next-state and next-output decode; everything holds unless changed.
    always_comb begin
        state_nxt = state_r;
        code_nxt  = code_r;
        grant_nxt = grant_r;
        valid_nxt = valid_r;
        count_nxt = count_r;
`ifdef LAB_ARB_ROUND_ROBIN_EN
        ptr_nxt   = ptr_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    state_nxt = ST_BUSY;
                    code_nxt  = win_s;
                    grant_nxt = N'(onehot(5'(win_s), N));
                    valid_nxt = 1'b1;
                    count_nxt = count_r + LAB_ARB_CNT_W'(1);
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (ack) begin
                    state_nxt = ST_IDLE;
                    valid_nxt = 1'b0;
                    grant_nxt = '0;
`ifdef LAB_ARB_ROUND_ROBIN_EN
                    // Next search starts just below the index just served.
                    ptr_nxt = (code_r == '0) ? W'(N - 1) : (code_r - W'(1));
`endif
                end else begin
                    state_nxt = ST_BUSY;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                valid_nxt = 1'b0;
                grant_nxt = '0;
            end
        endcase
    end

    // State, output and pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            code_r  <= '0;
            grant_r <= '0;
            valid_r <= 1'b0;
            count_r <= '0;
`ifdef LAB_ARB_ROUND_ROBIN_EN
            ptr_r   <= W'(N - 1);
`endif
        end else begin
            state_r <= state_nxt;
            code_r  <= code_nxt;
            grant_r <= grant_nxt;
            valid_r <= valid_nxt;
            count_r <= count_nxt;
`ifdef LAB_ARB_ROUND_ROBIN_EN
            ptr_r   <= ptr_nxt;
`endif
        end
    end

    assign code  = code_r;
    assign grant = grant_r;
    assign valid = valid_r;
    assign count = count_r;

endmodule

// File: tb/tb_lab_encoder_arbiter.sv
// Self-checking bench for lab_encoder_arbiter (N = 5). Directed scenarios
// plus a randomized phase, all compared against a cycle-level reference
// model derived from the grant/hold/ack rules.
module tb_lab_encoder_arbiter;

    logic       clk;
    logic       rst;
    logic [4:0] req;
    logic       ack;
    logic [2:0] code;
    logic [4:0] grant;
    logic       valid;
    logic [7:0] count;

    int errors;
    int checks;

    // Reference model state
    int         m_code;
    logic [4:0] m_grant;
    bit         m_valid;
    int         m_count;
    int         m_ptr;

    lab_encoder_arbiter #(.N(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .ack   (ack),
        .code  (code),
        .grant (grant),
        .valid (valid),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Winner selection from the priority rules.
    function automatic int pick(input logic [4:0] r, input int p);
        int w;
        w = -1;
`ifdef LAB_ARB_ROUND_ROBIN_EN
        for (int k = 0; k < 5; k++) begin
            int i;
            i = (p - k + 5) % 5;
            if (w < 0 && r[i]) w = i;
        end
`else
        for (int i = 4; i >= 0; i--) begin
            if (w < 0 && r[i]) w = i;
        end
`endif
        return w;
    endfunction

    task automatic model_update(input logic [4:0] r, input logic a, input logic rs);
        int w;
        if (rs) begin
            m_code = 0; m_grant = 5'd0; m_valid = 0; m_count = 0; m_ptr = 4;
        end else if (m_valid) begin
            if (a) begin
                m_valid = 0;
                m_grant = 5'd0;
                m_ptr   = (m_code + 4) % 5;
            end
        end else begin
            w = pick(r, m_ptr);
            if (w >= 0) begin
                m_code  = w;
                m_grant = 5'(1 << w);
                m_valid = 1;
                m_count = (m_count + 1) % 256;
            end
        end
    endtask

    task automatic check_all(input string tag);
        checks++;
        assert (valid === m_valid) else begin
            errors++;
            $error("FAIL %s valid: observed %0b expected %0b", tag, valid, m_valid);
        end
        checks++;
        assert (code === 3'(m_code)) else begin
            errors++;
            $error("FAIL %s code: observed %0d expected %0d", tag, code, m_code);
        end
        checks++;
        assert (grant === m_grant) else begin
            errors++;
            $error("FAIL %s grant: observed %b expected %b", tag, grant, m_grant);
        end
        checks++;
        assert (count === 8'(m_count)) else begin
            errors++;
            $error("FAIL %s count: observed %0d expected %0d", tag, count, m_count);
        end
    endtask

    task automatic step(input logic [4:0] r, input logic a, input logic rs, input string tag);
        req = r; ack = a; rst = rs;
        @(posedge clk);
        #1;
        model_update(r, a, rs);
        check_all(tag);
    endtask

    task automatic expect_val(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs == exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    initial begin
        logic [4:0] r;
        errors = 0; checks = 0;
        m_code = 0; m_grant = 5'd0; m_valid = 0; m_count = 0; m_ptr = 4;
        req = 5'd0; ack = 1'b0; rst = 1'b1;

        // 1. Reset with all requests asserted
        step(5'b11111, 1'b0, 1'b1, "reset0");
        step(5'b11111, 1'b0, 1'b1, "reset1");
        expect_val("reset_valid", int'(valid), 0);
        step(5'b11111, 1'b0, 1'b0, "first_after_reset");
        expect_val("first_code", int'(code), 4);
        step(5'b00000, 1'b0, 1'b1, "reset2");

        // 2. Grant and hold
        step(5'b00011, 1'b0, 1'b0, "grant_011");
        expect_val("grant_011_code", int'(code), 1);
        expect_val("grant_011_grant", int'(grant), 2);
        expect_val("grant_011_count", int'(count), 1);
        for (int i = 0; i < 10; i++) step(5'b11111, 1'b0, 1'b0, "hold");
        expect_val("hold_code", int'(code), 1);

        // 3. Release and re-grant
        step(5'b01001, 1'b1, 1'b0, "release");
        expect_val("release_valid", int'(valid), 0);
        step(5'b01001, 1'b0, 1'b0, "regrant");
`ifndef LAB_ARB_ROUND_ROBIN_EN
        expect_val("regrant_code", int'(code), 3);
        expect_val("regrant_grant", int'(grant), 8);
`endif
        expect_val("regrant_count", int'(count), 2);
        step(5'b00000, 1'b1, 1'b0, "release2");

        // 4. Constant full load: grant then ack, repeated
        step(5'b00000, 1'b0, 1'b1, "reset3");
        for (int i = 0; i < 6; i++) begin
            step(5'b11111, 1'b0, 1'b0, "load_grant");
`ifdef LAB_ARB_ROUND_ROBIN_EN
            expect_val("rr_order", int'(code), (4 - i + 5) % 5);
`else
            expect_val("fixed_order", int'(code), 4);
`endif
            step(5'b11111, 1'b1, 1'b0, "load_ack");
        end

        // 5. Idle ack ignored, then count wrap over 256 grants
        step(5'b00000, 1'b1, 1'b0, "idle_ack");
        step(5'b00000, 1'b0, 1'b0, "idle_quiet");
        expect_val("idle_valid", int'(valid), 0);
        for (int i = 0; i < 256; i++) begin
            r = 5'($urandom_range(1, 31));
            step(r, 1'b0, 1'b0, "wrap_grant");
            step(5'($urandom_range(0, 31)), 1'b1, 1'b0, "wrap_ack");
        end
        expect_val("wrap_count", int'(count), 6);

        // 6. Reset during BUSY with ack
        step(5'b00000, 1'b0, 1'b1, "reset4");
        step(5'b00100, 1'b0, 1'b0, "busy_code2");
        expect_val("busy_code2_code", int'(code), 2);
        step(5'b00100, 1'b1, 1'b1, "rst_in_busy");
        expect_val("rst_busy_count", int'(count), 0);
        step(5'b11111, 1'b0, 1'b0, "after_rst");
        expect_val("after_rst_code", int'(code), 4);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(5'($urandom_range(0, 31)), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 59) == 0), "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
